// File: rtl/alu_4bit_checker_if.sv
//------------------------------------------------------------------------------
// Module  : alu_4bit_checker_if
// Brief   : Vector/result bus between an ALU test source and its checker.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface alu_4bit_checker_if #(
    parameter int CNT_W = 8
);
    logic             valid_i;
    logic [3:0]       A_i;
    logic [3:0]       B_i;
    logic [1:0]       Control_i;
    logic [3:0]       R_i;
    logic             clear_i;
    logic [CNT_W-1:0] pass_cnt_o;
    logic [CNT_W-1:0] fail_cnt_o;
    logic             error_o;
    logic [1:0]       state_o;
    logic [13:0]      fail_vec_o;
    logic [3:0]       fail_exp_o;

    modport master (
        output valid_i, A_i, B_i, Control_i, R_i, clear_i,
        input  pass_cnt_o, fail_cnt_o, error_o, state_o, fail_vec_o, fail_exp_o
    );

    modport slave (
        input  valid_i, A_i, B_i, Control_i, R_i, clear_i,
        output pass_cnt_o, fail_cnt_o, error_o, state_o, fail_vec_o, fail_exp_o
    );
endinterface

`default_nettype wire

// File: rtl/alu_4bit_checker.sv
//------------------------------------------------------------------------------
// Module  : alu_4bit_checker
// Brief   : Two-stage golden-model checker for a 4-bit ALU result path.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_4bit_checker #(
    parameter int CNT_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    alu_4bit_checker_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FAIL = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;
    logic             r_v1;
    logic [3:0]       r_a1;
    logic [3:0]       r_b1;
    logic [1:0]       r_c1;
    logic [3:0]       r_r1;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_error;
    logic [13:0]      r_fail_vec;
    logic [3:0]       r_fail_exp;
    logic [3:0]       w_golden;
    logic             w_match;
    logic             w_flush;

    // Reset and clear both flush the pipe, so neither stage may compare.
    assign w_flush = rst_i || bus.clear_i;

    always_comb begin
        w_golden = 4'd0;
        case (r_c1)
            2'b00:   w_golden = r_a1 + r_b1;
            2'b01:   w_golden = r_a1 - r_b1;
            2'b10:   w_golden = r_a1 | r_b1;
            default: w_golden = r_a1 & r_b1;
        endcase
    end

    assign w_match = (w_golden == r_r1);

    always_comb begin
        w_state_next = r_state;
        if (r_v1) begin
            if (!w_match)
                w_state_next = ST_FAIL;
            else if (r_state == ST_IDLE)
                w_state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_flush)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk_i) begin
        if (w_flush) begin
            r_v1 <= 1'b0;
            r_a1 <= 4'd0;
            r_b1 <= 4'd0;
            r_c1 <= 2'd0;
            r_r1 <= 4'd0;
        end else begin
            r_v1 <= bus.valid_i;
            if (bus.valid_i) begin
                r_a1 <= bus.A_i;
                r_b1 <= bus.B_i;
                r_c1 <= bus.Control_i;
                r_r1 <= bus.R_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_flush) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_error    <= 1'b0;
            r_fail_vec <= 14'd0;
            r_fail_exp <= 4'd0;
        end else if (r_v1) begin
            if (w_match) begin
                if (r_pass_cnt != c_cnt_max)
                    r_pass_cnt <= r_pass_cnt + c_cnt_one;
            end else begin
                if (r_fail_cnt != c_cnt_max)
                    r_fail_cnt <= r_fail_cnt + c_cnt_one;
                r_error <= 1'b1;
                // Only the first mismatch since reset/clear is kept for debug.
                if (r_state != ST_FAIL) begin
                    r_fail_vec <= {r_a1, r_b1, r_c1, r_r1};
                    r_fail_exp <= w_golden;
                end
            end
        end
    end

    assign bus.pass_cnt_o = r_pass_cnt;
    assign bus.fail_cnt_o = r_fail_cnt;
    assign bus.error_o    = r_error;
    assign bus.state_o    = r_state;
    assign bus.fail_vec_o = r_fail_vec;
    assign bus.fail_exp_o = r_fail_exp;

endmodule

`default_nettype wire

// File: tb/tb_alu_4bit_checker.sv
//------------------------------------------------------------------------------
// Module  : tb_alu_4bit_checker
// Brief   : Directed-vector bench for alu_4bit_checker (CNT_W=8 and CNT_W=2).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_4bit_checker;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_4bit_checker_if #(.CNT_W(8)) bus8();
    alu_4bit_checker_if #(.CNT_W(2)) bus2();

    alu_4bit_checker #(.CNT_W(8)) u_dut8 (.clk_i(clk), .rst_i(rst), .bus(bus8));
    alu_4bit_checker #(.CNT_W(2)) u_dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Both instances see identical stimulus; inputs change on the falling edge.
    task automatic put(input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] c, input logic [3:0] r);
        bus8.valid_i = 1'b1; bus8.A_i = a; bus8.B_i = b; bus8.Control_i = c; bus8.R_i = r;
        bus2.valid_i = 1'b1; bus2.A_i = a; bus2.B_i = b; bus2.Control_i = c; bus2.R_i = r;
        @(negedge clk);
    endtask

    task automatic gap(input int n);
        bus8.valid_i = 1'b0;
        bus2.valid_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_clear(input logic v);
        bus8.clear_i = v;
        bus2.clear_i = v;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        set_clear(1'b0);
        gap(2);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++;
        if (bus8.pass_cnt_o !== 8'd0) begin n_fail++; $display("FAIL reset_pass: got %0h expected 0", bus8.pass_cnt_o); end
        n_checks++;
        if (bus8.fail_cnt_o !== 8'd0) begin n_fail++; $display("FAIL reset_fail: got %0h expected 0", bus8.fail_cnt_o); end
        n_checks++;
        if (bus8.error_o !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %0b expected 0", bus8.error_o); end
        n_checks++;
        if (bus8.state_o !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %0b expected 00", bus8.state_o); end
        n_checks++;
        if (bus8.fail_vec_o !== 14'd0) begin n_fail++; $display("FAIL reset_vec: got %0h expected 0", bus8.fail_vec_o); end
        n_checks++;
        if (bus8.fail_exp_o !== 4'd0) begin n_fail++; $display("FAIL reset_exp: got %0h expected 0", bus8.fail_exp_o); end
    endtask

    task automatic test_single_pass;
        do_reset();
        put(4'd1, 4'd2, 2'b00, 4'd3);
        gap(1);
        // Two rising edges have passed since valid_i was sampled.
        n_checks++;
        if (bus8.pass_cnt_o !== 8'd1) begin n_fail++; $display("FAIL single_pass: got %0h expected 1", bus8.pass_cnt_o); end
        n_checks++;
        if (bus8.error_o !== 1'b0) begin n_fail++; $display("FAIL single_error: got %0b expected 0", bus8.error_o); end
        n_checks++;
        if (bus8.state_o !== 2'b01) begin n_fail++; $display("FAIL single_state: got %0b expected 01", bus8.state_o); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        put(4'd2, 4'd1, 2'b01, 4'd1);
        put(4'd1, 4'd2, 2'b10, 4'd3);
        put(4'd1, 4'd3, 2'b11, 4'd1);
        put(4'hF, 4'd1, 2'b00, 4'd0);
        put(4'd0, 4'd1, 2'b01, 4'hF);
        gap(2);
        n_checks++;
        if (bus8.pass_cnt_o !== 8'd5) begin n_fail++; $display("FAIL b2b_pass: got %0h expected 5", bus8.pass_cnt_o); end
        n_checks++;
        if (bus8.fail_cnt_o !== 8'd0) begin n_fail++; $display("FAIL b2b_fail: got %0h expected 0", bus8.fail_cnt_o); end
        n_checks++;
        if (bus8.state_o !== 2'b01) begin n_fail++; $display("FAIL b2b_state: got %0b expected 01", bus8.state_o); end
    endtask

    task automatic test_mismatch;
        put(4'd1, 4'd2, 2'b00, 4'd4);
        put(4'd2, 4'd1, 2'b01, 4'd7);
        gap(2);
        n_checks++;
        if (bus8.fail_cnt_o !== 8'd2) begin n_fail++; $display("FAIL mis_fail: got %0h expected 2", bus8.fail_cnt_o); end
        n_checks++;
        if (bus8.pass_cnt_o !== 8'd5) begin n_fail++; $display("FAIL mis_pass: got %0h expected 5", bus8.pass_cnt_o); end
        n_checks++;
        if (bus8.error_o !== 1'b1) begin n_fail++; $display("FAIL mis_error: got %0b expected 1", bus8.error_o); end
        n_checks++;
        if (bus8.state_o !== 2'b10) begin n_fail++; $display("FAIL mis_state: got %0b expected 10", bus8.state_o); end
        n_checks++;
        if (bus8.fail_vec_o !== 14'h0484) begin n_fail++; $display("FAIL mis_vec: got %0h expected 484", bus8.fail_vec_o); end
        n_checks++;
        if (bus8.fail_exp_o !== 4'd3) begin n_fail++; $display("FAIL mis_exp: got %0h expected 3", bus8.fail_exp_o); end
        // FAIL state holds through a later matching vector.
        put(4'd1, 4'd1, 2'b00, 4'd2);
        gap(2);
        n_checks++;
        if (bus8.state_o !== 2'b10) begin n_fail++; $display("FAIL mis_hold_state: got %0b expected 10", bus8.state_o); end
    endtask

    task automatic test_clear;
        set_clear(1'b1);
        put(4'd1, 4'd2, 2'b00, 4'd3);
        set_clear(1'b0);
        gap(3);
        n_checks++;
        if (bus8.pass_cnt_o !== 8'd0) begin n_fail++; $display("FAIL clr_pass: got %0h expected 0", bus8.pass_cnt_o); end
        n_checks++;
        if (bus8.fail_cnt_o !== 8'd0) begin n_fail++; $display("FAIL clr_fail: got %0h expected 0", bus8.fail_cnt_o); end
        n_checks++;
        if (bus8.error_o !== 1'b0) begin n_fail++; $display("FAIL clr_error: got %0b expected 0", bus8.error_o); end
        n_checks++;
        if (bus8.state_o !== 2'b00) begin n_fail++; $display("FAIL clr_state: got %0b expected 00", bus8.state_o); end
        n_checks++;
        if (bus8.fail_vec_o !== 14'd0) begin n_fail++; $display("FAIL clr_vec: got %0h expected 0", bus8.fail_vec_o); end
        n_checks++;
        if (bus8.fail_exp_o !== 4'd0) begin n_fail++; $display("FAIL clr_exp: got %0h expected 0", bus8.fail_exp_o); end
        // Vector sitting in stage 1 when clear arrives is discarded too.
        put(4'd1, 4'd2, 2'b00, 4'd3);
        bus8.valid_i = 1'b0;
        bus2.valid_i = 1'b0;
        set_clear(1'b1);
        @(negedge clk);
        set_clear(1'b0);
        gap(3);
        n_checks++;
        if (bus8.pass_cnt_o !== 8'd0) begin n_fail++; $display("FAIL clr_stage1_pass: got %0h expected 0", bus8.pass_cnt_o); end
        put(4'd3, 4'd4, 2'b00, 4'd7);
        gap(2);
        n_checks++;
        if (bus8.pass_cnt_o !== 8'd1) begin n_fail++; $display("FAIL clr_next_pass: got %0h expected 1", bus8.pass_cnt_o); end
        n_checks++;
        if (bus8.state_o !== 2'b01) begin n_fail++; $display("FAIL clr_next_state: got %0b expected 01", bus8.state_o); end
    endtask

    task automatic test_saturation;
        do_reset();
        put(4'd0, 4'd0, 2'b00, 4'd1);
        put(4'd1, 4'd1, 2'b00, 4'd0);
        put(4'd2, 4'd2, 2'b00, 4'd0);
        put(4'd3, 4'd3, 2'b11, 4'd0);
        put(4'd4, 4'd4, 2'b10, 4'd0);
        gap(2);
        n_checks++;
        if (bus2.fail_cnt_o !== 2'd3) begin n_fail++; $display("FAIL sat_fail2: got %0h expected 3", bus2.fail_cnt_o); end
        n_checks++;
        if (bus2.error_o !== 1'b1) begin n_fail++; $display("FAIL sat_error2: got %0b expected 1", bus2.error_o); end
        n_checks++;
        if (bus2.fail_vec_o !== 14'h0001) begin n_fail++; $display("FAIL sat_vec2: got %0h expected 1", bus2.fail_vec_o); end
        n_checks++;
        if (bus8.fail_cnt_o !== 8'd5) begin n_fail++; $display("FAIL sat_fail8: got %0h expected 5", bus8.fail_cnt_o); end
        do_reset();
        repeat (5) put(4'd7, 4'd9, 2'b00, 4'd0);
        gap(2);
        n_checks++;
        if (bus2.pass_cnt_o !== 2'd3) begin n_fail++; $display("FAIL sat_pass2: got %0h expected 3", bus2.pass_cnt_o); end
        n_checks++;
        if (bus8.pass_cnt_o !== 8'd5) begin n_fail++; $display("FAIL sat_pass8: got %0h expected 5", bus8.pass_cnt_o); end
    endtask

    task automatic test_reset_inflight;
        do_reset();
        put(4'd1, 4'd2, 2'b00, 4'd3);
        bus8.valid_i = 1'b0;
        bus2.valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        gap(3);
        n_checks++;
        if (bus8.pass_cnt_o !== 8'd0) begin n_fail++; $display("FAIL rst_fly_pass: got %0h expected 0", bus8.pass_cnt_o); end
        n_checks++;
        if (bus8.fail_cnt_o !== 8'd0) begin n_fail++; $display("FAIL rst_fly_fail: got %0h expected 0", bus8.fail_cnt_o); end
        n_checks++;
        if (bus8.state_o !== 2'b00) begin n_fail++; $display("FAIL rst_fly_state: got %0b expected 00", bus8.state_o); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus8.valid_i = 1'b0; bus8.A_i = 4'd0; bus8.B_i = 4'd0; bus8.Control_i = 2'd0; bus8.R_i = 4'd0; bus8.clear_i = 1'b0;
        bus2.valid_i = 1'b0; bus2.A_i = 4'd0; bus2.B_i = 4'd0; bus2.Control_i = 2'd0; bus2.R_i = 4'd0; bus2.clear_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_pass();
        test_back_to_back();
        test_mismatch();
        test_clear();
        test_saturation();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
